// File: rtl/seg_pkg.sv
// Shared constants, scan-state type and small helpers for the two-digit
// 7-segment scan controller.
package seg_pkg;

    localparam logic [6:0] SEG_ONE   = 7'b1001111;
    localparam logic [6:0] SEG_TWO   = 7'b0010010;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        BLANK_R,
        SHOW_R,
        BLANK_L,
        SHOW_L
    } scan_state_t;

    function automatic logic [6:0] glyph(input logic sel);
        return sel ? SEG_TWO : SEG_ONE;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
// level_next is the value the debounced register takes at the coming edge.
module switch_debounce
    import seg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic level_next
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        level_next = level;
        cnt_next   = '0;
        if (sync2 != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_next = sync2;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            level <= level_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed two-digit 7-segment driver: right digit shows the record
// clip, left digit the play clip, each blinking while its operation is active.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES     = 100_000,
    parameter int unsigned BLANK_CYCLES    = 1_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch0,
    input  logic       switch1,
    input  logic       rec_active,
    input  logic       play_active,
    output logic       a0,
    output logic       a1,
    output logic [6:0] cathode
);

    localparam int unsigned SLOT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned SCW      = cnt_width(SLOT_MAX);
    localparam int unsigned BCW      = cnt_width(BLINK_CYCLES);

    scan_state_t    state;
    scan_state_t    state_next;
    logic [SCW-1:0] slot_cnt;
    logic [SCW-1:0] slot_cnt_next;
    logic [SCW-1:0] slot_last;
    logic [BCW-1:0] blink_cnt;
    logic [BCW-1:0] blink_cnt_next;
    logic           blink_phase;
    logic           blink_phase_next;
    logic [6:0]     glyph_r;
    logic [6:0]     glyph_r_next;
    logic [6:0]     glyph_l;
    logic [6:0]     glyph_l_next;
    logic           a0_next;
    logic           a1_next;
    logic [6:0]     cathode_next;
    logic           rec_sel_next;
    logic           play_sel_next;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rec (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (switch0),
        .level_next(rec_sel_next)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (switch1),
        .level_next(play_sel_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BLANK_R;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state; the glyph latch sees a debounce update landing on the
    // same edge that enters the slot.
    always_comb begin
        state_next    = state;
        slot_cnt_next = slot_cnt + 1'b1;
        slot_last     = ((state == SHOW_R) || (state == SHOW_L)) ? SCW'(SHOW_CYCLES - 1)
                                                                 : SCW'(BLANK_CYCLES - 1);
        if (slot_cnt == slot_last) begin
            slot_cnt_next = '0;
            case (state)
                BLANK_R: state_next = SHOW_R;
                SHOW_R:  state_next = BLANK_L;
                BLANK_L: state_next = SHOW_L;
                default: state_next = BLANK_R;
            endcase
        end

        blink_cnt_next   = blink_cnt + 1'b1;
        blink_phase_next = blink_phase;
        if (blink_cnt == BCW'(BLINK_CYCLES - 1)) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase;
        end

        glyph_r_next = glyph_r;
        glyph_l_next = glyph_l;
        if ((state_next == SHOW_R) && (state != SHOW_R)) begin
            glyph_r_next = glyph(rec_sel_next);
        end
        if ((state_next == SHOW_L) && (state != SHOW_L)) begin
            glyph_l_next = glyph(play_sel_next);
        end

        a0_next      = 1'b1;
        a1_next      = 1'b1;
        cathode_next = SEG_BLANK;
        case (state_next)
            SHOW_R: begin
                a0_next = 1'b0;
                if (!(rec_active && !blink_phase_next)) begin
                    cathode_next = glyph_r_next;
                end
            end
            SHOW_L: begin
                a1_next = 1'b0;
                if (!(play_active && !blink_phase_next)) begin
                    cathode_next = glyph_l_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            glyph_r     <= SEG_ONE;
            glyph_l     <= SEG_ONE;
            a0          <= 1'b1;
            a1          <= 1'b1;
            cathode     <= SEG_BLANK;
        end else begin
            slot_cnt    <= slot_cnt_next;
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
            glyph_r     <= glyph_r_next;
            glyph_l     <= glyph_l_next;
            a0          <= a0_next;
            a1          <= a1_next;
            cathode     <= cathode_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: a timeline/debounce reference model
// queues the expected pins for every cycle, and a monitor compares them.
module tb_seg_scan_controller;

    localparam int unsigned S  = 4;
    localparam int unsigned B  = 2;
    localparam int unsigned D  = 3;
    localparam int unsigned BL = 20;
    localparam int unsigned P  = 2 * (B + S);

    localparam logic [6:0] G_ONE = 7'b1001111;
    localparam logic [6:0] G_TWO = 7'b0010010;
    localparam logic [6:0] G_OFF = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       switch0 = 1'b0;
    logic       switch1 = 1'b0;
    logic       rec_active = 1'b0;
    logic       play_active = 1'b0;
    logic       a0;
    logic       a1;
    logic [6:0] cathode;

    typedef struct {
        logic        a0;
        logic        a1;
        logic [6:0]  cat;
        int unsigned k;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int unsigned k = 0;
    bit          raw_hist[2][2];
    bit          deb[2];
    int unsigned streak[2];
    bit          sel_r = 1'b0;
    bit          sel_l = 1'b0;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .SHOW_CYCLES    (S),
        .BLANK_CYCLES   (B),
        .DEBOUNCE_CYCLES(D),
        .BLINK_CYCLES   (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .switch0    (switch0),
        .switch1    (switch1),
        .rec_active (rec_active),
        .play_active(play_active),
        .a0         (a0),
        .a1         (a1),
        .cathode    (cathode)
    );

    function automatic logic [6:0] glyph_of(input bit sel);
        return sel ? G_TWO : G_ONE;
    endfunction

    // One clock edge of the reference model with the inputs as driven now.
    task automatic model_edge();
        exp_t        e;
        bit          sw[2];
        bit          synced;
        int unsigned pos;
        bit          dark;
        sw[0] = switch0;
        sw[1] = switch1;
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < 2; i++) begin
                raw_hist[i][0] = 1'b0;
                raw_hist[i][1] = 1'b0;
                deb[i]         = 1'b0;
                streak[i]      = 0;
            end
        end else begin
            k = k + 1;
            for (int i = 0; i < 2; i++) begin
                synced         = raw_hist[i][1];
                raw_hist[i][1] = raw_hist[i][0];
                raw_hist[i][0] = sw[i];
                if (synced != deb[i]) begin
                    streak[i] = streak[i] + 1;
                    if (streak[i] == D) begin
                        deb[i]    = synced;
                        streak[i] = 0;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
        end
        pos  = k % P;
        dark = ((k / BL) % 2) == 1;
        if (pos == B) sel_r = deb[0];
        if (pos == 2 * B + S) sel_l = deb[1];
        e.k   = k;
        e.a0  = 1'b1;
        e.a1  = 1'b1;
        e.cat = G_OFF;
        if (pos >= B && pos < B + S) begin
            e.a0 = 1'b0;
            if (!(rec_active && dark)) e.cat = glyph_of(sel_r);
        end else if (pos >= 2 * B + S) begin
            e.a1 = 1'b0;
            if (!(play_active && dark)) e.cat = glyph_of(sel_l);
        end
        q.push_back(e);
    endtask

    task automatic drive_cycle(input logic rst, input logic s0, input logic s1,
                               input logic rec, input logic play);
        @(negedge clk);
        rst_n       = rst;
        switch0     = s0;
        switch1     = s1;
        rec_active  = rec;
        play_active = play;
        model_edge();
    endtask

    // Monitor: one expected entry per clock edge, sampled 2 time units after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks = checks + 4;
                if (a0 !== e.a0) begin
                    errors = errors + 1;
                    $display("FAIL a0 k=%0d: got %b want %b", e.k, a0, e.a0);
                end
                if (a1 !== e.a1) begin
                    errors = errors + 1;
                    $display("FAIL a1 k=%0d: got %b want %b", e.k, a1, e.a1);
                end
                if (cathode !== e.cat) begin
                    errors = errors + 1;
                    $display("FAIL cathode k=%0d: got %b want %b", e.k, cathode, e.cat);
                end
                if (!(a0 === 1'b0 && a1 === 1'b0)) begin
                end else begin
                    errors = errors + 1;
                    $display("FAIL anode_overlap k=%0d: got a0=%b a1=%b want not both 0", e.k, a0, a1);
                end
            end
        end
    end

    initial begin
        int unsigned hold0;
        int unsigned hold1;
        int unsigned holdr;
        int unsigned holdp;
        logic        s0;
        logic        s1;
        logic        rec;
        logic        play;

        // Reset held, then idle timeline with both selects at clip 1
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Record select to clip 2
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Short play-select glitches must never be accepted
        for (int i = 0; i < 35; i++) drive_cycle(1'b1, 1'b1, (i % 7) < 2, 1'b0, 1'b0);
        // Play select to clip 2, held
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // Recording active: right digit blinks
        for (int i = 0; i < 80; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        // Playback active, record select back to clip 1
        for (int i = 0; i < 80; i++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        // Reset pulse mid-operation with both selects high
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Randomised holds so debounce updates land at every slot position
        s0 = 1'b1; s1 = 1'b1; rec = 1'b0; play = 1'b0;
        hold0 = 1; hold1 = 1; holdr = 1; holdp = 1;
        for (int i = 0; i < 3000; i++) begin
            if (--hold0 == 0) begin s0 = ~s0;   hold0 = $urandom_range(1, 12); end
            if (--hold1 == 0) begin s1 = ~s1;   hold1 = $urandom_range(1, 12); end
            if (--holdr == 0) begin rec = ~rec;  holdr = $urandom_range(1, 60); end
            if (--holdp == 0) begin play = ~play; holdp = $urandom_range(1, 60); end
            drive_cycle(($urandom_range(0, 299) != 0), s0, s1, rec, play);
        end

        for (int t = 0; t < 10 && q.size() > 0; t++) begin
            @(posedge clk);
            #3;
        end
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
